// File: rtl/if_id_skid_stage_if.sv
// IF->ID handshake bundle: fetch-side valid/ready/bus, flush, decode-side ready and unpacked fields.
// master = environment driving the stage, slave = the stage itself.
interface if_id_skid_stage_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    localparam int BUS_W = 2 * PC_WIDTH + INSTR_WIDTH + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [BUS_W-1:0]       if_id_bus;
    logic                   flush;
    logic                   id_ready;
    logic                   out_valid;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc_4;
    logic                   out_diffen;
    logic [31:0]            flush_drop_cnt;

    modport master (
        output in_valid, if_id_bus, flush, id_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pc_4, out_diffen, flush_drop_cnt
    );

    modport slave (
        input  in_valid, if_id_bus, flush, id_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pc_4, out_diffen, flush_drop_cnt
    );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a two-entry (main + skid) buffer, flush and NOP injection.
// Latency: one cycle from accept to out_* when main is free or firing.
// Backpressure: in_ready is a flop (~skid valid); no combinational path from id_ready to in_ready.
module if_id_skid_stage #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst,
    if_id_skid_stage_if.slave ifid
);
    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc_4;
        logic                   diffen;
    } bundle_t;

    bundle_t     bus_dat;
    bundle_t     m_dat;
    bundle_t     s_dat;
    logic        m_vld;
    logic        s_vld;
    logic        in_rdy_q;
    logic [31:0] drop_cnt;

    logic        accept;
    logic        fire;
    logic [1:0]  drop_inc;

    assign bus_dat = ifid.if_id_bus;
    assign accept  = ifid.in_valid & in_rdy_q & ~ifid.flush;
    assign fire    = m_vld & ifid.id_ready;

    // A main entry that decode takes in the flush cycle was delivered, not dropped.
    always_comb begin
        drop_inc = 2'd0;
        drop_inc = {1'b0, m_vld & ~ifid.id_ready} + {1'b0, s_vld} + {1'b0, ifid.in_valid};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld    <= 1'b0;
            s_vld    <= 1'b0;
            in_rdy_q <= 1'b1;
            m_dat    <= '0;
            s_dat    <= '0;
            drop_cnt <= '0;
        end else if (ifid.flush) begin
            m_vld    <= 1'b0;
            s_vld    <= 1'b0;
            in_rdy_q <= 1'b1;
            drop_cnt <= drop_cnt + {30'd0, drop_inc};
        end else if (!m_vld || fire) begin
            if (s_vld) begin
                // in_ready was low, so nothing new can arrive while the skid drains.
                m_vld    <= 1'b1;
                m_dat    <= s_dat;
                s_vld    <= 1'b0;
                in_rdy_q <= 1'b1;
            end else begin
                m_vld <= accept;
                if (accept) begin
                    m_dat <= bus_dat;
                end
            end
        end else if (accept) begin
            s_vld    <= 1'b1;
            s_dat    <= bus_dat;
            in_rdy_q <= 1'b0;
        end
    end

    assign ifid.in_ready       = in_rdy_q;
    assign ifid.out_valid      = m_vld;
    assign ifid.out_pc         = m_dat.pc;
    assign ifid.out_pc_4       = m_dat.pc_4;
    assign ifid.out_instr      = m_vld ? m_dat.instr : NOP_INSTR;
    assign ifid.out_diffen     = m_vld & m_dat.diffen;
    assign ifid.flush_drop_cnt = drop_cnt;

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) s_vld |-> m_vld);

    a_ready_tracks_skid: assert property (@(posedge clk) disable iff (rst) in_rdy_q == ~s_vld);

    // With the skid full and decode stalled, the stage must look frozen to both neighbours.
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (s_vld && !ifid.id_ready && !ifid.flush) |=>
            $stable({ifid.out_valid, ifid.out_pc, ifid.out_instr, ifid.out_pc_4,
                     ifid.out_diffen, ifid.in_ready}));
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed vector table, hand-written reset/flush sequences,
// and a randomized run against a two-deep FIFO reference model.
module tb_if_id_skid_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_id_skid_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) ifc ();

    if_id_skid_stage #(.PC_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk  (clk),
        .rst  (rst),
        .ifid (ifc.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        idr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic        e_ir;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    function automatic logic [96:0] mk_bus(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic diffen);
        return {pc, instr, pc + 32'd4, diffen};
    endfunction

    function automatic logic [96:0] tbl_bus(input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        return mk_bus(p, instr_of(p), p[2]);
    endfunction

    task automatic drive(input logic iv, input logic [31:0] pc, input logic fl, input logic idr);
        ifc.in_valid  = iv;
        ifc.if_id_bus = tbl_bus(pc);
        ifc.flush     = fl;
        ifc.id_ready  = idr;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".in_ready"},  32'(ifc.in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, ".out_instr"}, ifc.out_instr, NOP);
        chk({tag, ".out_pc"},    ifc.out_pc, 32'd0);
        chk({tag, ".out_pc_4"},  ifc.out_pc_4, 32'd0);
        chk({tag, ".out_diffen"}, 32'(ifc.out_diffen), 32'd0);
        chk({tag, ".drop_cnt"},  ifc.flush_drop_cnt, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [96:0] q[$];
        int unsigned mcnt;
        logic        iv, fl, idr, mir;
        logic [96:0] bus;
        logic [31:0] rpc;

        // ---- table -----------------------------------------------------------
        //              iv  pc            fl idr  ov  exp pc        ir cnt
        vecs[0]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 32'd0};
        vecs[1]  = '{1'b1, 32'h8000_0004, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'd0};
        vecs[2]  = '{1'b1, 32'h8000_0008, 1'b0, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'd0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'd0};
        vecs[4]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'd0};
        vecs[5]  = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'd0};
        vecs[6]  = '{1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'd0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'd0};
        vecs[9]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'd0};
        vecs[10] = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'd0};
        vecs[11] = '{1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'd3};
        vecs[12] = '{1'b1, 32'h8000_000C, 1'b0, 1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'd3};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'd3};
        vecs[14] = '{1'b1, 32'h8000_0010, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'd4};
        vecs[15] = '{1'b1, 32'h8000_0014, 1'b0, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'd4};
        vecs[16] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'd5};

        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_reset_outputs("reset");

        tick();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].idr);
            tick();
            chk($sformatf("v%0d.out_valid", i), 32'(ifc.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d.in_ready", i), 32'(ifc.in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d.drop_cnt", i), ifc.flush_drop_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d.out_instr", i), ifc.out_instr,
                vecs[i].e_ov ? instr_of(vecs[i].e_pc) : NOP);
            chk($sformatf("v%0d.out_diffen", i), 32'(ifc.out_diffen),
                32'(vecs[i].e_ov & vecs[i].e_pc[2]));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d.out_pc", i), ifc.out_pc, vecs[i].e_pc);
                chk($sformatf("v%0d.out_pc_4", i), ifc.out_pc_4, vecs[i].e_pc + 32'd4);
            end
        end

        // ---- async reset mid-stream with skid full; flush during reset -------------
        drive(1'b1, 32'h8000_0020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8000_0024, 1'b0, 1'b0);
        tick();
        chk("pre_rst.in_ready", 32'(ifc.in_ready), 32'd0);
        drive(1'b1, 32'h8000_0028, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        drive(1'b1, 32'h8000_002C, 1'b1, 1'b0);
        tick();
        chk("rst_flush.drop_cnt", ifc.flush_drop_cnt, 32'd0);
        chk("rst_flush.out_valid", 32'(ifc.out_valid), 32'd0);
        #2 rst = 1'b0;
        drive(1'b1, 32'h8000_0100, 1'b0, 1'b1);
        tick();
        chk("post_rst.out_valid", 32'(ifc.out_valid), 32'd1);
        chk("post_rst.out_pc", ifc.out_pc, 32'h8000_0100);
        chk("post_rst.in_ready", 32'(ifc.in_ready), 32'd1);

        // ---- randomized run against a two-deep FIFO model ---------------------------
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        q.delete();
        mcnt = 0;
        rpc  = $urandom & 32'hFFFF_FFFC;
        for (int c = 0; c < 3000; c++) begin
            iv  = ($urandom_range(0, 99) < 70);
            fl  = ($urandom_range(0, 99) < 8);
            idr = ($urandom_range(0, 99) < 60);
            bus = mk_bus(rpc, $urandom, 1'($urandom_range(0, 1)));
            ifc.in_valid  = iv;
            ifc.if_id_bus = bus;
            ifc.flush     = fl;
            ifc.id_ready  = idr;

            mir = (q.size() < 2);
            if (fl) begin
                mcnt += ((q.size() > 0 && !idr) ? 1 : 0) + ((q.size() == 2) ? 1 : 0) + (iv ? 1 : 0);
                q.delete();
            end else begin
                if (q.size() > 0 && idr) void'(q.pop_front());
                if (iv && mir) begin
                    q.push_back(bus);
                    rpc = rpc + 32'd4;
                end
            end

            tick();
            chk("rnd.out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
            chk("rnd.in_ready", 32'(ifc.in_ready), 32'(q.size() < 2));
            chk("rnd.drop_cnt", ifc.flush_drop_cnt, 32'(mcnt));
            if (q.size() > 0) begin
                chk("rnd.out_pc", ifc.out_pc, q[0][96:65]);
                chk("rnd.out_instr", ifc.out_instr, q[0][64:33]);
                chk("rnd.out_pc_4", ifc.out_pc_4, q[0][32:1]);
                chk("rnd.out_diffen", 32'(ifc.out_diffen), 32'(q[0][0]));
            end else begin
                chk("rnd.nop", ifc.out_instr, NOP);
                chk("rnd.diffen_gate", 32'(ifc.out_diffen), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
